// File: rtl/gps_code_serializer.sv
// gps_code_serializer: buffers 128-bit L-code blocks from the gps generator in a
// small circular FIFO and streams each block out as four 32-bit words (MSW first)
// over a valid/ready interface. Blocks arriving to a full FIFO are dropped and
// latched into a sticky overflow flag.
module gps_code_serializer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [127:0]                 l_code,
    input  logic                         l_code_valid,
    output logic [31:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned LevelW = $clog2(DEPTH + 1);

    logic [127:0]        mem_q [DEPTH];
    logic [AddrW-1:0]    wp_q, wp_d;
    logic [AddrW-1:0]    rp_q, rp_d;
    logic [1:0]          idx_q, idx_d;
    logic [LevelW-1:0]   level_q, level_d;
    logic                ovf_q, ovf_d;

    logic                xfer;
    logic                pop;
    logic                push;
    logic                drop;
    logic [127:0]        head;

    // Outputs decoded purely from registered state; no input reaches them.
    always_comb begin
        out_valid = (level_q != '0);
        head      = mem_q[rp_q];
        out_data  = head[127:96];
        unique case (idx_q)
            2'd0: out_data = head[127:96];
            2'd1: out_data = head[95:64];
            2'd2: out_data = head[63:32];
            2'd3: out_data = head[31:0];
            default: out_data = head[127:96];
        endcase
        out_last  = out_valid & (idx_q == 2'd3);
        level     = level_q;
        overflow  = ovf_q;
    end

    // Next-state: a full FIFO still accepts a block if its head is popped this cycle.
    always_comb begin
        xfer  = out_valid & out_ready;
        pop   = xfer & (idx_q == 2'd3);
        push  = l_code_valid & ((level_q < LevelW'(DEPTH)) | pop);
        drop  = l_code_valid & ~push;

        wp_d    = wp_q;
        rp_d    = rp_q;
        idx_d   = idx_q;
        level_d = level_q;
        ovf_d   = ovf_q;

        if (push) begin
            wp_d = wp_q + AddrW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AddrW'(1);
        end
        // idx wraps 3 -> 0 naturally on the popping transfer.
        if (xfer) begin
            idx_d = idx_q + 2'd1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Pointer and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            idx_q   <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Block storage; contents deliberately survive reset, only pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wp_q] <= l_code;
        end
    end

endmodule
